sm83_mem_bus: RTL and testbench

SM83_MEM_BUS -- requirements
Module: sm83_mem_bus

---
 rtl/sm83_mem_bus.sv | 176 +++++++++++++++++
 tb/tb_sm83_mem_bus.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_mem_bus.sv
// SM83 memory bus: decodes CPU accesses onto HRAM, IE, IO and external memory,
// and runs the OAM DMA engine that takes over the external bus while active.
module sm83_mem_bus (
  input  logic        clk,
  input  logic        reset,
  input  logic        t1,
  input  logic        t2,
  input  logic        t3,
  input  logic        t4,
  input  logic [15:0] adr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        n_rd,
  input  logic        n_wr,
  input  logic        ext_data_lh,
  output logic [15:0] mem_adr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  io_adr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_ACTIVE} dma_state_t;
  typedef enum logic [1:0] {RD_NONE, RD_LATCHED, RD_IO, RD_MEM} rd_src_t;

  // Only t3 and t4 carry meaning for this block.
  logic unused_phases;
  assign unused_phases = t1 ^ t2;

  logic rd_cyc, wr_cyc;
  logic sel_hram, sel_ie, sel_io, sel_dma, sel_mem;

  assign rd_cyc   = ext_data_lh & t3;
  assign wr_cyc   = ~n_rd & n_wr & t3;
  assign sel_ie   = (adr == 16'hFFFF);
  assign sel_hram = (adr[15:7] == 9'h1FF) && !sel_ie;
  assign sel_io   = (adr[15:7] == 9'h1FE);
  assign sel_dma  = (adr == 16'hFF46);
  assign sel_mem  = (adr < 16'hFF00);

  dma_state_t state, state_d;
  logic [7:0] idx, idx_d;
  logic       start_cnt, start_cnt_d;
  logic       restart, restart_d;
  logic [7:0] src, ie, eff_src;
  logic       dma_busy, dma_xfer, dma_wr, cpu_mem_ok;

  // A restart keeps the bus owned by DMA through its START delay.
  assign dma_busy   = (state == DMA_ACTIVE) || restart;
  assign dma_xfer   = (state == DMA_ACTIVE);
  assign dma_wr     = wr_cyc && sel_dma;
  assign cpu_mem_ok = sel_mem && !dma_busy;
  assign eff_src    = (src >= 8'hE0) ? (src & 8'hDF) : src;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_d     = state;
    idx_d       = idx;
    start_cnt_d = start_cnt;
    restart_d   = restart;
    case (state)
      DMA_START: begin
        if (t4) begin
          if (start_cnt) begin
            start_cnt_d = 1'b0;
          end else begin
            state_d   = DMA_ACTIVE;
            restart_d = 1'b0;
          end
        end
      end
      DMA_ACTIVE: begin
        if (t4) begin
          if (idx == 8'd159) begin
            state_d = DMA_IDLE;
            idx_d   = 8'd0;
          end else begin
            idx_d = idx + 8'd1;
          end
        end
      end
      default: ;
    endcase
    // Two t4 edges of delay: the rest of the writing M-cycle plus one full one.
    if (dma_wr) begin
      state_d     = DMA_START;
      idx_d       = 8'd0;
      start_cnt_d = 1'b1;
      restart_d   = dma_busy;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= DMA_IDLE;
      idx       <= 8'd0;
      start_cnt <= 1'b0;
      restart   <= 1'b0;
      src       <= 8'd0;
      ie        <= 8'd0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      start_cnt <= start_cnt_d;
      restart   <= restart_d;
      if (dma_wr)            src <= cpu_wdata;
      if (wr_cyc && sel_ie)  ie  <= cpu_wdata;
    end
  end

  // NOTE: HRAM contents are deliberately not reset; only control state is.
  logic [7:0] hram [0:126];

  always_ff @(posedge clk) begin
    if (wr_cyc && sel_hram) hram[adr[6:0]] <= cpu_wdata;
  end

  // Internal sources are captured at t3; IO and memory data arrive during t4.
  rd_src_t    rd_src;
  logic [7:0] rd_latch;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_src   <= RD_NONE;
      rd_latch <= 8'hFF;
    end else if (rd_cyc) begin
      rd_src   <= RD_LATCHED;
      rd_latch <= 8'hFF;
      if (sel_hram)        rd_latch <= hram[adr[6:0]];
      else if (sel_ie)     rd_latch <= ie;
      else if (sel_dma)    rd_latch <= src;
      else if (sel_io)     rd_src   <= RD_IO;
      else if (cpu_mem_ok) rd_src   <= RD_MEM;
    end else begin
      rd_src <= RD_NONE;
    end
  end

  always_comb begin
    cpu_rdata = 8'hFF;
    if (!reset && t4) begin
      case (rd_src)
        RD_LATCHED: cpu_rdata = rd_latch;
        RD_IO:      cpu_rdata = io_rdata;
        RD_MEM:     cpu_rdata = mem_rdata;
        default:    cpu_rdata = 8'hFF;
      endcase
    end
  end

  assign mem_rd     = !reset && ((rd_cyc && cpu_mem_ok) || (dma_xfer && t3));
  assign mem_wr     = !reset && wr_cyc && cpu_mem_ok;
  assign mem_adr    = reset ? 16'h0000 : ((dma_xfer && t3) ? {eff_src, idx} : adr);
  assign mem_wdata  = reset ? 8'h00 : cpu_wdata;
  assign io_rd      = !reset && rd_cyc && sel_io;
  assign io_wr      = !reset && wr_cyc && sel_io;
  assign io_adr     = reset ? 7'h00 : adr[6:0];
  assign io_wdata   = reset ? 8'h00 : cpu_wdata;
  assign oam_we     = !reset && dma_xfer && t4;
  assign oam_adr    = reset ? 8'h00 : idx;
  assign oam_wdata  = reset ? 8'h00 : mem_rdata;
  assign dma_active = !reset && dma_busy;

endmodule

// File: tb/tb_sm83_mem_bus.sv
// Scoreboard bench for sm83_mem_bus: stimulus queues expected bus events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sm83_mem_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        t1, t2, t3, t4;
  logic [15:0] adr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        n_rd, n_wr, ext_data_lh;
  logic [15:0] mem_adr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [6:0]  io_adr;
  logic        io_rd, io_wr;
  logic [7:0]  io_wdata, io_rdata;
  logic        oam_we;
  logic [7:0]  oam_adr, oam_wdata;
  logic        dma_active;

  always #5 clk = ~clk;

  sm83_mem_bus dut (
    .clk(clk), .reset(reset), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
    .adr(adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .n_rd(n_rd), .n_wr(n_wr), .ext_data_lh(ext_data_lh),
    .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_adr(io_adr), .io_rd(io_rd), .io_wr(io_wr),
    .io_wdata(io_wdata), .io_rdata(io_rdata),
    .oam_we(oam_we), .oam_adr(oam_adr), .oam_wdata(oam_wdata),
    .dma_active(dma_active)
  );

  // Expected events: mem reads {adr}, mem writes {adr,data},
  // io {wr,adr,data}, oam {adr,data}, cpu read data.
  logic [15:0] mem_q [$];
  logic [23:0] memw_q [$];
  logic [15:0] io_q [$];
  logic [15:0] oam_q [$];
  logic [7:0]  rd_q [$];

  int   checks = 0;
  int   errors = 0;
  int   oam_seen = 0;
  logic rd_pending = 1'b0;
  logic act_and, act_or, t4_oam_we, t4_act;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // External memory content pattern, one clk read latency.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  always @(posedge clk) if (mem_rd) mem_rdata <= mem_val(mem_adr);

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd) begin
        if (mem_q.size() == 0) check("mem_rd_unexpected", 32'(mem_rd), 32'd0);
        else check("mem_rd_adr", 32'(mem_adr), 32'(mem_q.pop_front()));
      end
      if (mem_wr) begin
        if (memw_q.size() == 0) check("mem_wr_unexpected", 32'(mem_wr), 32'd0);
        else check("mem_wr", 32'({mem_adr, mem_wdata}), 32'(memw_q.pop_front()));
      end
      if (io_rd || io_wr) begin
        if (io_q.size() == 0) check("io_unexpected", 32'({io_rd, io_wr}), 32'd0);
        else check("io_access", 32'({io_wr, io_adr, io_wdata}), 32'(io_q.pop_front()));
      end
      if (oam_we) begin
        oam_seen++;
        if (oam_q.size() == 0) check("oam_we_unexpected", 32'(oam_we), 32'd0);
        else check("oam_write", 32'({oam_adr, oam_wdata}), 32'(oam_q.pop_front()));
      end
      if (t4 && rd_pending && rd_q.size() != 0)
        check("cpu_rdata", 32'(cpu_rdata), 32'(rd_q.pop_front()));
      rd_pending = t3 && ext_data_lh;
    end
  end

  // One M-cycle; reset can be raised during its t4 to hit a transfer mid-flight.
  task automatic mcycle(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] iod, input logic rst4);
    act_and = 1'b1;
    act_or  = 1'b0;
    for (int p = 0; p < 4; p++) begin
      {t1, t2, t3, t4} = 4'b1000 >> p;
      adr         = a;
      cpu_wdata   = wd;
      io_rdata    = iod;
      n_rd        = !wr;
      n_wr        = wr && (p == 2);
      ext_data_lh = rd && (p == 2);
      reset       = rst4 && (p == 3);
      @(negedge clk);
      act_and &= dma_active;
      act_or  |= dma_active;
      if (p == 3) begin
        t4_oam_we = oam_we;
        t4_act    = dma_active;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic blocked);
    if (a[15:7] == 9'h1FE) io_q.push_back({1'b1, a[6:0], d});
    else if (a < 16'hFF00 && !blocked) memw_q.push_back({a, d});
    mcycle(1'b0, 1'b1, a, d, 8'h00, 1'b0);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp,
                          input logic [7:0] iod, input logic blocked);
    rd_q.push_back(exp);
    if (a[15:7] == 9'h1FE) io_q.push_back({1'b0, a[6:0], 8'h00});
    else if (a < 16'hFF00 && !blocked) mem_q.push_back(a);
    mcycle(1'b1, 1'b0, a, 8'h00, iod, 1'b0);
  endtask

  // eff is the hand-computed effective source page.
  task automatic push_dma(input logic [7:0] eff);
    for (int i = 0; i < 160; i++) begin
      mem_q.push_back({eff, 8'(i)});
      oam_q.push_back({8'(i), mem_val({eff, 8'(i)})});
    end
  endtask

  task automatic wait_oam(input int n);
    int guard;
    guard = 0;
    while (oam_seen < n && guard < 400) begin
      idle();
      guard++;
    end
    check("wait_oam_count", 32'(oam_seen), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    // Reset with every input pushing toward an access.
    reset = 1'b1;
    {t1, t2, t3, t4} = 4'b0010;
    adr = 16'h1234; cpu_wdata = 8'hA5; io_rdata = 8'h77;
    n_rd = 1'b0; n_wr = 1'b1; ext_data_lh = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    check("rst_strobes", 32'({mem_rd, mem_wr, io_rd, io_wr, oam_we}), 32'd0);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_mem_adr", 32'(mem_adr), 32'd0);
    check("rst_io_adr", 32'(io_adr), 32'd0);
    check("rst_oam_adr", 32'(oam_adr), 32'd0);
    check("rst_wdata", 32'({mem_wdata, io_wdata, oam_wdata}), 32'd0);
    @(posedge clk);
    #1;

    // CPU path: HRAM, IE, IO, DMA register, external memory.
    cpu_write(16'hFF90, 8'h5A, 1'b0);
    cpu_read (16'hFF90, 8'h5A, 8'h00, 1'b0);
    cpu_write(16'hFFFF, 8'h1F, 1'b0);
    cpu_read (16'hFFFF, 8'h1F, 8'h00, 1'b0);
    cpu_read (16'hFF05, 8'h33, 8'h33, 1'b0);
    cpu_write(16'hFF10, 8'h44, 1'b0);
    cpu_write(16'hFF80, 8'h77, 1'b0);
    cpu_read (16'hFF46, 8'h00, 8'hEE, 1'b0);
    cpu_write(16'h2000, 8'hC3, 1'b0);
    cpu_read (16'h1234, mem_val(16'h1234), 8'h00, 1'b0);

    // DMA from C1 with CPU traffic during the transfer.
    oam_seen = 0;
    push_dma(8'hC1);
    cpu_write(16'hFF46, 8'hC1, 1'b0);
    idle();
    check("start_delay_inactive", 32'(act_or), 32'd0);
    check("start_delay_no_oam", 32'(oam_seen), 32'd0);
    cpu_read (16'h8000, 8'hFF, 8'h00, 1'b1);
    check("first_xfer_active", 32'(act_and), 32'd1);
    cpu_write(16'hC000, 8'h99, 1'b1);
    cpu_read (16'hFF80, 8'h77, 8'h00, 1'b1);
    cpu_read (16'hFF46, 8'hC1, 8'h00, 1'b1);
    wait_oam(160);
    idle();
    check("dma_done_inactive", 32'(act_or), 32'd0);
    check("dma_done_queues", 32'(oam_q.size() + mem_q.size()), 32'd0);

    // DMA from E2 (mirrors to C2), restarted from D0 at idx 50.
    oam_seen = 0;
    push_dma(8'hC2);
    cpu_write(16'hFF46, 8'hE2, 1'b0);
    wait_oam(50);
    oam_q.delete();
    while (mem_q.size() > 1) void'(mem_q.pop_back());
    push_dma(8'hD0);
    oam_seen = 0;
    cpu_write(16'hFF46, 8'hD0, 1'b1);
    check("restart_wr_active", 32'(act_and), 32'd1);
    idle();
    check("restart_delay_active", 32'(act_and), 32'd1);
    check("restart_delay_no_oam", 32'(oam_seen), 32'd0);
    idle();
    check("restart_xfer_active", 32'(act_and), 32'd1);
    wait_oam(80);

    // Reset lands on the t4 of transfer 80.
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b1);
    check("rst_mid_oam_we", 32'(t4_oam_we), 32'd0);
    check("rst_mid_dma_active", 32'(t4_act), 32'd0);
    reset = 1'b1;
    {t1, t2, t3, t4} = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    oam_q.delete();
    mem_q.delete();
    cpu_read(16'hFFFF, 8'h00, 8'h00, 1'b0);
    cpu_read(16'hFF46, 8'h00, 8'h00, 1'b0);
    repeat (3) begin
      idle();
      check("post_reset_inactive", 32'(act_or), 32'd0);
    end

    check("final_queues_empty",
          32'(mem_q.size() + memw_q.size() + io_q.size() + oam_q.size() + rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
